rand_sample_monitor: RTL and testbench
======================================

// Module: rand_sample_monitor
// PURPOSE
//  Downstream consumer of the 8-bit LFSR random generator. Buffers each newly
//  generated value in a small FIFO with a valid/ready read side. Also measures
//  the generator period: the number of advances between visits to the seed
//  state, as flagged by the generator's done signal. Sits between the LFSR and
//  any consumer that cannot take a sample every cycle.
// PARAMETERS
//  WIDTH       8    sample width; matches generator RandNum
//  DEPTH       8    FIFO entries; power of two, >= 2
//  CNT_W       16   period counter width
//  EXP_PERIOD  255  expected period; a mismatch raises period_err
// PORTS
//  clk          in   1           system clock, rising edge
//  rst_n        in   1           asynchronous active-low reset
//  rand_in      in   WIDTH       generator RandNum (current state)
//  rand_adv     in   1           generator Enable: state advances at this edge
//  gen_done     in   1           generator Gen_done: state == seed (level)
//  seed_en      in   1           generator seed load, same cycle as generator
//  out_data     out  WIDTH       FIFO head
//  out_valid    out  1           FIFO not empty
//  out_ready    in   1           consumer accepts head this cycle
//  level        out  $clog2(DEPTH)+1  entries held
//  full         out  1           level == DEPTH
//  overflow     out  1           sticky: a sample was dropped
//  period       out  CNT_W       last measured period
//  period_valid out  1           1-cycle pulse when period updates
//  period_err   out  1           sticky: measured period != EXP_PERIOD, or timeout
// BEHAVIOUR
//  Reset (rst_n=0, async): FIFO empty, pointers 0, out_valid=0, level=0,
//   full=0, overflow=0, period=0, period_valid=0, period_err=0, FSM=IDLE, cnt=0.
//   out_data is don't-care while out_valid=0.
//  FIFO:
//   push = rand_adv & ~seed_en. rand_in is written in the same cycle.
//   pop = out_valid & out_ready.
//   A push is accepted if ~full, or if full and pop is asserted in the same cycle.
//   A push while full with no pop is dropped and sets overflow; no other state changes.
//   Latency: a push in cycle N gives out_valid=1 and out_data=that value in N+1.
//   Simultaneous push and pop: level is unchanged, and both pointers advance mod DEPTH.
//   out_data = mem[rd_ptr], driven from registers with no combinational path
//   from rand_in.
//   seed_en does not flush the FIFO.
//  Period FSM, with states IDLE, ARMED, MEASURE, TIMEOUT:
//   seed_en (any state) -> ARMED. Also sets cnt=0 and clears overflow and period_err.
//   ARMED: the first cycle with gen_done & rand_adv moves to MEASURE with cnt=1.
//   MEASURE, evaluated in priority order:
//    gen_done & cnt!=0: period<=cnt, period_valid=1, period_err|=(cnt!=EXP_PERIOD),
//      cnt<=rand_adv?1:0.
//    else if rand_adv: cnt<=cnt+1.
//    If cnt reaches 2^CNT_W-1 before any capture: -> TIMEOUT, period_err=1.
//   gen_done held high with rand_adv=0 captures only once, because cnt becomes 0.
//   TIMEOUT: holds until seed_en. No captures take place in IDLE, ARMED or TIMEOUT.
//   period_valid is high for exactly one cycle per capture.
//  seed_en has priority over all FSM transitions in the same cycle.
//  Reset mid-operation: all state is lost immediately, and no partial period is reported.
// TESTING
//  1. Reset, then 4 pushes of 0x11,0x22,0x33,0x44 with out_ready=0 ->
//     level=4, out_data=0x11. Then out_ready=1 for 4 cycles -> pops in order,
//     then out_valid=0.
//  2. DEPTH+2 pushes, out_ready=0 -> full=1, level=8, overflow=1, and entries
//     hold the first 8 values. At full, push and pop together -> level stays 8,
//     and the new value lands at the tail.
//  3. seed_en with seed 0xA5, then rand_adv=1 continuously, with a model
//     generator of period 255 -> period_valid pulses every 255 advances,
//     period=255, period_err=0.
//  4. Same as 3, but rand_adv toggles 1/0 -> period is still 255, and
//     captures are 510 cycles apart.
//  5. Model generator with period 254 -> period=254, period_err=1 (sticky).
//     Then seed_en -> period_err=0.
//  6. CNT_W=8 with gen_done held 0 after arming -> TIMEOUT after 255 advances,
//     period_err=1, no period_valid. Assert rst_n=0 mid-MEASURE -> all outputs
//     at reset values asynchronously.

Source files
------------

// File: rtl/rand_sample_monitor.sv
// -----------------------------------------------------------------------------
// rand_sample_monitor
//
// Consumer-side companion to the 8-bit LFSR random generator.
//  * Buffers every newly generated value in a small FIFO with a valid/ready
//    read side, so a consumer that cannot take a sample each cycle still sees
//    the values in order. If the FIFO is full, new samples are dropped and a
//    sticky overflow flag is set.
//  * Measures the generator period, which is the number of advances between
//    visits to the seed state, and flags any period other than EXP_PERIOD.
//
// Ports
//  clk           in   system clock, rising edge
//  rst_n         in   asynchronous active-low reset
//  rand_in       in   generator current state (RandNum)
//  rand_adv      in   generator advances at this edge (Enable)
//  gen_done      in   generator state equals seed (level)
//  seed_en       in   generator seed load; re-arms the period measurement
//  out_data      out  FIFO head, valid while out_valid
//  out_valid     out  FIFO not empty
//  out_ready     in   consumer takes the head this cycle
//  level         out  number of entries held
//  full          out  level == DEPTH
//  overflow      out  sticky: a sample was dropped (cleared by seed_en)
//  period        out  last measured period
//  period_valid  out  one-cycle pulse when period updates
//  period_err    out  sticky: bad period or counter timeout (cleared by seed_en)
// -----------------------------------------------------------------------------
module rand_sample_monitor #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         rand_in,
    input  logic                     rand_adv,
    input  logic                     gen_done,
    input  logic                     seed_en,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [CNT_W-1:0]         period,
    output logic                     period_valid,
    output logic                     period_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST   = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_EXP    = CNT_W'(EXP_PERIOD);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, TIMEOUT} state_t;

    // ------------------------------------------------------------------ FIFO
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop, accept;

    // A seed load is not a new sample, even if the generator is enabled.
    assign push      = rand_adv & ~seed_en;
    assign pop       = out_valid & out_ready;
    // When full, a push can still go in if the head leaves in the same cycle.
    assign accept    = push & (~full | pop);

    assign out_valid = (count != '0);
    assign full      = (count == LEVEL_FULL);
    assign level     = count;
    assign out_data  = mem[rd_ptr];

    // NOTE: storage has no reset; out_valid gates every read, so stale
    // contents are never observed and the array can map to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= rand_in;
        end
    end

    // NOTE: every clocked block uses non-blocking assignments so all state
    // updates see the pre-edge values, exactly as the hardware does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;   // wraps: DEPTH is 2^AW
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (seed_en) begin
                overflow <= 1'b0;
            end else if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ period FSM
    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             capture, timeout_hit;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        if (seed_en) begin
            state_d = ARMED;
            cnt_d   = '0;
        end else begin
            case (state)
                ARMED: begin
                    // The advance that leaves the seed state counts as one.
                    if (gen_done && rand_adv) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_ONE;
                    end
                end
                MEASURE: begin
                    // cnt != 0 makes a gen_done level held without advancing
                    // capture once only.
                    if (gen_done && (cnt != '0)) begin
                        capture = 1'b1;
                        cnt_d   = rand_adv ? CNT_ONE : '0;
                    end else if (rand_adv) begin
                        cnt_d = cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state_d     = TIMEOUT;
                            timeout_hit = 1'b1;
                        end
                    end
                end
                default: ;   // IDLE and TIMEOUT wait for seed_en
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            period_err   <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            period_valid <= capture;
            if (capture) period <= cnt;
            if (seed_en) begin
                period_err <= 1'b0;
            end else if ((capture && (cnt != CNT_EXP)) || timeout_hit) begin
                period_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rand_sample_monitor.sv
// -----------------------------------------------------------------------------
// tb_rand_sample_monitor
//
// Two instances share clock, reset and stimulus: "dut" uses the default
// parameters, and "dut_t" uses CNT_W=8 so the counter timeout can be reached
// quickly. A queue model predicts the FIFO stream. A generator model with a
// chosen period predicts the captured periods. The negedge monitor pops the
// expectations and compares them with the outputs of both instances.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rand_sample_monitor;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 8;
    localparam int CNT_W      = 16;
    localparam int EXP_PERIOD = 255;
    localparam int LW         = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] rand_in = '0;
    logic             rand_adv = 1'b0;
    logic             gen_done = 1'b0;
    logic             gen_done_t = 1'b0;
    logic             seed_en = 1'b0;
    logic             out_ready = 1'b0;

    logic [WIDTH-1:0] out_data, t_out_data;
    logic             out_valid, t_out_valid;
    logic [LW-1:0]    level, t_level;
    logic             full, t_full, overflow, t_overflow;
    logic [CNT_W-1:0] period;
    logic [7:0]       t_period;
    logic             period_valid, t_period_valid, period_err, t_period_err;

    rand_sample_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD)) dut (
        .clk(clk), .rst_n(rst_n), .rand_in(rand_in), .rand_adv(rand_adv),
        .gen_done(gen_done), .seed_en(seed_en), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .level(level), .full(full),
        .overflow(overflow), .period(period), .period_valid(period_valid),
        .period_err(period_err)
    );

    rand_sample_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(8), .EXP_PERIOD(EXP_PERIOD)) dut_t (
        .clk(clk), .rst_n(rst_n), .rand_in(rand_in), .rand_adv(rand_adv),
        .gen_done(gen_done_t), .seed_en(seed_en), .out_data(t_out_data),
        .out_valid(t_out_valid), .out_ready(out_ready), .level(t_level), .full(t_full),
        .overflow(t_overflow), .period(t_period), .period_valid(t_period_valid),
        .period_err(t_period_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ FIFO model
    logic [WIDTH-1:0] exp_q[$];
    int               exp_level = 0;
    bit               exp_ovf = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                exp_level = 0;
                exp_ovf   = 1'b0;
            end else begin
                bit pop_m, push_m, acc;
                pop_m  = (exp_level > 0) && out_ready;
                push_m = rand_adv && !seed_en;
                acc    = push_m && ((exp_level < DEPTH) || pop_m);
                if (seed_en) exp_ovf = 1'b0;
                if (push_m && !acc) exp_ovf = 1'b1;
                if (acc) exp_q.push_back(rand_in);
                exp_level = exp_level + int'(acc) - int'(pop_m);
            end
        end
    end

    // ---------------------------------------------------- period expectations
    typedef struct {
        int per;
        bit err;
    } per_t;
    per_t exp_per_q[$];
    bit   exp_err = 1'b0;
    int   cap_times[$];
    int   cap_cnt = 0;
    int   t_pv_cnt = 0;
    int   cyc = 0;

    // --------------------------------------------------------------- monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                check("level", level, exp_level);
                check("full", full, exp_level == DEPTH);
                check("out_valid", out_valid, exp_level != 0);
                check("overflow", overflow, exp_ovf);
                check("t_level", t_level, exp_level);
                check("t_overflow", t_overflow, exp_ovf);
                if (out_valid && out_ready) begin
                    check("sb_fifo_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        check("t_out_data", t_out_data, exp_q[0]);
                        check("out_data", out_data, exp_q.pop_front());
                    end
                end
                if (period_valid) begin
                    cap_times.push_back(cyc);
                    cap_cnt++;
                    check("sb_period_nonempty", exp_per_q.size() != 0, 1);
                    if (exp_per_q.size() != 0) begin
                        per_t e;
                        e = exp_per_q.pop_front();
                        check("period", period, e.per);
                        check("period_err_at_capture", period_err, e.err);
                    end
                end
                if (t_period_valid) t_pv_cnt++;
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic drive(input bit adv, input bit seed, input bit gd, input bit gdt,
                         input logic [7:0] din, input bit rdy);
        rand_adv   = adv;
        seed_en    = seed;
        gen_done   = gd;
        gen_done_t = gdt;
        rand_in    = din;
        out_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_seed();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom), 1'($urandom));
        exp_err = 1'b0;
    endtask

    // Generator model with period p: state index k, k==0 is the seed (0xA5).
    task automatic run_gen(input int p, input bit toggle, input int loops);
        int k = 0;
        int adv_n = 0;
        int done = 0;
        int cap0 = cap_cnt;
        bit adv;
        cap_times.delete();
        for (int c = 0; done < loops && c < 5000; c++) begin
            adv = toggle ? (c % 2 == 0) : 1'b1;
            drive(adv, 1'b0, k == 0, 1'b0, 8'(165 + k), 1'($urandom));
            if (adv) begin
                k++;
                adv_n++;
                if (k == p) begin
                    k = 0;
                    exp_err = exp_err | (adv_n != EXP_PERIOD);
                    exp_per_q.push_back('{adv_n, exp_err});
                    adv_n = 0;
                    done++;
                end
            end
        end
        // Stay on the seed without advancing, which must not capture again.
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'($urandom));
        check("capture_count", cap_cnt - cap0, loops);
        check("sb_period_drained", exp_per_q.size(), 0);
        for (int i = 1; i < cap_times.size(); i++)
            check("capture_gap", cap_times[i] - cap_times[i-1], toggle ? 2 * p : p);
    endtask

    initial begin
        // Reset values
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_period", period, 0);
        check("rst_period_valid", period_valid, 0);
        check("rst_period_err", period_err, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: four pushes, then drain in order
        drive(1, 0, 0, 0, 8'h11, 0);
        drive(1, 0, 0, 0, 8'h22, 0);
        drive(1, 0, 0, 0, 8'h33, 0);
        drive(1, 0, 0, 0, 8'h44, 0);
        check("t1_level", level, 4);
        check("t1_head", out_data, 8'h11);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 8'h00, 1);
        check("t1_empty", out_valid, 0);

        // 2: DEPTH+2 pushes, overflow, then push+pop at full
        for (int i = 0; i < DEPTH + 2; i++) drive(1, 0, 0, 0, 8'(8'h50 + i), 0);
        check("t2_full", full, 1);
        check("t2_level", level, DEPTH);
        check("t2_overflow", overflow, 1);
        check("t2_head", out_data, 8'h50);
        drive(1, 0, 0, 0, 8'h99, 1);
        check("t2_level_pushpop", level, DEPTH);
        for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 0, 8'h00, 1);
        check("t2_empty", out_valid, 0);

        // 3: period 255, continuous advance
        do_seed();
        check("t3_ovf_cleared", overflow, 0);
        run_gen(255, 1'b0, 3);
        check("t3_period_err", period_err, 0);

        // 4: period 255, advancing every other cycle
        do_seed();
        run_gen(255, 1'b1, 2);
        check("t4_period_err", period_err, 0);

        // 5: period 254 -> sticky error, cleared by seed_en
        do_seed();
        run_gen(254, 1'b0, 2);
        check("t5_period_err", period_err, 1);
        do_seed();
        check("t5_err_cleared", period_err, 0);

        // 6: CNT_W=8 instance, gen_done stays low -> timeout after 255 advances
        do_seed();
        drive(1, 0, 0, 1, 8'($urandom), 1'($urandom));
        for (int i = 0; i < 253; i++) drive(1, 0, 0, 0, 8'($urandom), 1'($urandom));
        check("t6_err_before_timeout", t_period_err, 0);
        drive(1, 0, 0, 0, 8'($urandom), 1'($urandom));
        check("t6_err_timeout", t_period_err, 1);
        for (int i = 0; i < 6; i++) drive(1'(i % 2), 0, 0, 1, 8'($urandom), 1'($urandom));
        check("t6_no_capture", t_pv_cnt, 0);
        check("t6_err_held", t_period_err, 1);

        // Reset in the middle of a measurement with a full FIFO
        do_seed();
        drive(1, 0, 1, 1, 8'h5A, 0);
        for (int i = 0; i < DEPTH + 4; i++) drive(1, 0, 0, 0, 8'($urandom), 0);
        check("rst2_pre_overflow", overflow, 1);
        check("rst2_pre_period", period, 254);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst2_out_valid", out_valid, 0);
        check("rst2_level", level, 0);
        check("rst2_full", full, 0);
        check("rst2_overflow", overflow, 0);
        check("rst2_period", period, 0);
        check("rst2_period_valid", period_valid, 0);
        check("rst2_period_err", period_err, 0);
        check("rst2_t_out_valid", t_out_valid, 0);
        check("rst2_t_full", t_full, 0);
        check("rst2_t_period", t_period, 0);
        check("rst2_t_period_valid", t_period_valid, 0);
        check("rst2_t_period_err", t_period_err, 0);
        drive(0, 0, 0, 0, 8'h00, 0);
        drive(0, 0, 0, 0, 8'h00, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 8'hA5, 1);
        check("post_rst_no_capture", period_valid, 0);
        check("post_rst_sb_empty", exp_per_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
